// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, strobe encodings
// and owner-select values.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CORE   = 2'd1,
    ST_PERIPH = 2'd2
  } arb_state_e;

  localparam logic [1:0] STRB_BYTE = 2'd1;
  localparam logic [1:0] STRB_HALF = 2'd2;

  localparam logic OWN_CORE   = 1'b0;
  localparam logic OWN_PERIPH = 1'b1;

endpackage

// File: rtl/dmem_arb_mux.sv
// Combinational 2:1 memory-port mux; drives zeros when no requester owns the port.
module dmem_arb_mux
  import dmem_arb_pkg::*;
(
  input  logic        en,
  input  logic        sel,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [1:0]  core_strobe,
  input  logic        per_req,
  input  logic        per_we,
  input  logic [31:0] per_addr,
  input  logic [31:0] per_wdata,
  input  logic [1:0]  per_strobe,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_strobe,
  output logic        mem_wen
);

  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_strobe = '0;
    mem_wen    = 1'b0;
    if (en) begin
      if (sel == OWN_PERIPH) begin
        mem_addr   = per_addr;
        mem_wdata  = per_wdata;
        mem_strobe = per_strobe;
        mem_wen    = per_req & per_we;
      end else begin
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        mem_strobe = core_strobe;
        mem_wen    = core_req & core_we;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Core / peripheral-loader arbiter for the shared data memory with a burst limit.
// Optional round-robin tie-break on collisions: define DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_BITS = 9,
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [1:0]  core_strobe,
  output logic        core_gnt,
  output logic        core_stall,
  output logic [31:0] core_rdata,
  input  logic        per_req,
  input  logic        per_we,
  input  logic        per_lock,
  input  logic [31:0] per_addr,
  input  logic [31:0] per_wdata,
  input  logic [1:0]  per_strobe,
  output logic        per_gnt,
  output logic [31:0] per_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_strobe,
  output logic        mem_wen,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_CORE   = ST_CORE;
  localparam logic [1:0] S_PERIPH = ST_PERIPH;
  localparam int         CW       = $clog2(MAX_BURST) + 1;

  if (ADDR_BITS < 1 || ADDR_BITS > 32) begin : g_bad_cfg
    $error("dmem_arbiter: ADDR_BITS must be 1..32");
  end

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          burst_done;
  logic          pick_per;

  // cnt_q holds grant cycles already completed, so the current cycle is the
  // MAX_BURST-th when cnt_q reaches MAX_BURST-1.
  assign burst_done = (cnt_q >= CW'(MAX_BURST - 1));

`ifdef DMEM_ARB_RR_EN
  logic last_q;
  assign pick_per = (last_q == OWN_CORE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    last_q <= OWN_PERIPH;
    else if (state_q == S_CORE)   last_q <= OWN_CORE;
    else if (state_q == S_PERIPH) last_q <= OWN_PERIPH;
  end
`else
  assign pick_per = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CORE: begin
        if (burst_done && per_req) state_d = S_PERIPH;
        else if (core_req)         state_d = S_CORE;
        else                       state_d = per_req ? S_PERIPH : S_IDLE;
      end
      S_PERIPH: begin
        // An unlocked loader yields to a waiting core every cycle.
        if (burst_done && core_req)    state_d = S_CORE;
        else if (per_req && per_lock)  state_d = S_PERIPH;
        else if (core_req)             state_d = S_CORE;
        else                           state_d = per_req ? S_PERIPH : S_IDLE;
      end
      default: begin
        if (core_req && per_req) state_d = pick_per ? S_PERIPH : S_CORE;
        else if (core_req)       state_d = S_CORE;
        else if (per_req)        state_d = S_PERIPH;
        else                     state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
    else if (&cnt_q)                             cnt_d = cnt_q;
    else                                         cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign core_gnt   = (state_q == S_CORE);
  assign per_gnt    = (state_q == S_PERIPH);
  assign core_stall = core_req & ~core_gnt;
  assign core_rdata = core_gnt ? mem_rdata : '0;
  assign per_rdata  = per_gnt  ? mem_rdata : '0;

  dmem_arb_mux u_mux (
    .en          (core_gnt | per_gnt),
    .sel         (per_gnt ? OWN_PERIPH : OWN_CORE),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_strobe (core_strobe),
    .per_req     (per_req),
    .per_we      (per_we),
    .per_addr    (per_addr),
    .per_wdata   (per_wdata),
    .per_strobe  (per_strobe),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_strobe  (mem_strobe),
    .mem_wen     (mem_wen)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random traffic,
// compared against an owner/run-length reference model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int MAXB = 16;

  logic        clk = 1'b0, rst = 1'b1;
  logic        core_req = 0, core_we = 0;
  logic [31:0] core_addr = 0, core_wdata = 0;
  logic [1:0]  core_strobe = 0;
  logic        core_gnt, core_stall;
  logic [31:0] core_rdata;
  logic        per_req = 0, per_we = 0, per_lock = 0;
  logic [31:0] per_addr = 0, per_wdata = 0;
  logic [1:0]  per_strobe = 0;
  logic        per_gnt;
  logic [31:0] per_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_strobe;
  logic        mem_wen;
  logic [31:0] mem_rdata = 0;

  dmem_arbiter #(.ADDR_BITS(9), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_strobe(core_strobe),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rdata(core_rdata),
    .per_req(per_req), .per_we(per_we), .per_lock(per_lock),
    .per_addr(per_addr), .per_wdata(per_wdata), .per_strobe(per_strobe),
    .per_gnt(per_gnt), .per_rdata(per_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_strobe(mem_strobe),
    .mem_wen(mem_wen), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cg, pg, st, wen;
    logic [31:0] addr, wd;
    logic [1:0]  strb;
    logic [31:0] crd, prd;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;

  // Reference model: who owns the port, how many cycles it has held it,
  // and who was served last (1 = core, 2 = periph).
  int m_own = 0, m_run = 0, m_last = 2;

  function automatic void model_reset();
    m_own = 0; m_run = 0; m_last = 2;
  endfunction

  function automatic int pick_both();
`ifdef DMEM_ARB_RR_EN
    return (m_last == 1) ? 2 : 1;
`else
    return 1;
`endif
  endfunction

  function automatic void model_step();
    int  nxt;
    bool_dummy: begin end
    if (rst) begin model_reset(); return; end
    if (m_own == 0) begin
      if (core_req && per_req) nxt = pick_both();
      else nxt = core_req ? 1 : (per_req ? 2 : 0);
    end else if (m_own == 1) begin
      if (m_run + 1 >= MAXB && per_req) nxt = 2;
      else nxt = core_req ? 1 : (per_req ? 2 : 0);
    end else begin
      if (m_run + 1 >= MAXB && core_req) nxt = 1;
      else if (per_req && per_lock)      nxt = 2;
      else nxt = core_req ? 1 : (per_req ? 2 : 0);
    end
    m_run = (nxt == m_own && nxt != 0) ? m_run + 1 : 0;
    if (m_own != 0) m_last = m_own;
    m_own = nxt;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    e = '0;
    e.cg = (m_own == 1);
    e.pg = (m_own == 2);
    e.st = core_req && (m_own != 1);
    if (m_own == 1) begin
      e.addr = core_addr; e.wd = core_wdata; e.strb = core_strobe;
      e.wen = core_req && core_we; e.crd = mem_rdata;
    end else if (m_own == 2) begin
      e.addr = per_addr; e.wd = per_wdata; e.strb = per_strobe;
      e.wen = per_req && per_we; e.prd = mem_rdata;
    end
    return e;
  endfunction

  // Monitor: every pushed expectation is compared at the following negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = {core_gnt, per_gnt, core_stall, mem_wen, mem_addr, mem_wdata,
           mem_strobe, core_rdata, per_rdata};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, a, e);
      end
    end
  end

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t got %b expected %b", name, $time, act, req);
    end
  endtask

  task automatic step();
    q.push_back(expect_now());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_core(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] s);
    core_req = r; core_we = w; core_addr = a; core_wdata = d; core_strobe = s;
  endtask

  task automatic set_per(input logic r, input logic w, input logic l,
                         input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    per_req = r; per_we = w; per_lock = l; per_addr = a; per_wdata = d; per_strobe = s;
  endtask

  task automatic do_reset();
    set_core(0, 0, 0, 0, 0);
    set_per(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    bit seen;
    @(posedge clk); #1;
    // Reset state with a core request pending.
    core_req = 1'b1;
    #1;
    check1("rst_core_gnt", core_gnt, 1'b0);
    check1("rst_per_gnt", per_gnt, 1'b0);
    check1("rst_mem_wen", mem_wen, 1'b0);
    check1("rst_core_stall", core_stall, 1'b1);
    do_reset();

    // Single core write: one stall cycle, then grant with the write on the port.
    mem_rdata = 32'h1234_5678;
    set_core(1, 1, 32'h10, 32'hDEAD_BEEF, 2'd3);
    step(); step(); step();
    set_core(0, 0, 0, 0, 0);
    step();

    // Collisions from IDLE.
    set_core(1, 0, 32'h20, 32'h0, 2'd3);
    set_per(1, 0, 0, 32'h30, 32'h0, STRB_HALF);
    step(); step();
    set_core(0, 0, 0, 0, 0); set_per(0, 0, 0, 0, 0, 0);
    step(); step();
    set_core(1, 0, 32'h24, 32'h0, 2'd3);
    set_per(1, 1, 1, 32'h34, 32'h55, STRB_HALF);
    step(); step(); step();
    set_core(0, 0, 0, 0, 0); set_per(0, 0, 0, 0, 0, 0);
    step(); step();

    // Core releases while the loader waits: direct hand-over.
    set_core(1, 1, 32'h40, 32'h1, 2'd3);
    step(); step();
    set_core(0, 0, 0, 0, 0);
    set_per(1, 1, 0, 32'h44, 32'h2, 2'd3);
    step();
    check1("handover_per_gnt", per_gnt, 1'b1);
    step();
    set_per(0, 0, 0, 0, 0, 0);
    step();

    // Locked loader burst against a waiting core: capped at MAXB cycles.
    do_reset();
    run = 0; seen = 0;
    set_per(1, 1, 1, 32'h80, 32'hCAFE_0000, 2'd3);
    for (int c = 0; c < 40; c++) begin
      if (c == 3) set_core(1, 0, 32'h90, 32'h0, 2'd3);
      per_addr = 32'h80 + c;
      step();
      if (per_gnt && (run == 0 || seen == 0)) begin run++; seen = 0; end
      else if (!per_gnt && run > 0) seen = 1;
      if (seen && per_gnt) begin end
    end
    checks++;
    if (run != MAXB) begin
      errors++;
      $display("FAIL burst_len got %0d expected %0d", run, MAXB);
    end

    // Byte read by the loader.
    do_reset();
    mem_rdata = 32'h0BAD_F00D;
    set_per(1, 0, 0, 32'h1FC, 32'h0000_00A5, STRB_BYTE);
    step(); step(); step();

    // Asynchronous reset in the middle of a locked loader write burst.
    do_reset();
    set_per(1, 1, 1, 32'h100, 32'h77, 2'd3);
    step(); step(); step();
    q.push_back(expect_now());
    #6;
    check1("pre_rst_per_gnt", per_gnt, 1'b1);
    check1("pre_rst_mem_wen", mem_wen, 1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    check1("async_rst_per_gnt", per_gnt, 1'b0);
    check1("async_rst_mem_wen", mem_wen, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      set_core($urandom_range(99) < 70, $urandom_range(1), $urandom, $urandom,
               2'($urandom_range(3)));
      set_per($urandom_range(99) < 60, $urandom_range(1), $urandom_range(99) < 75,
              $urandom, $urandom, 2'($urandom_range(3)));
      mem_rdata = $urandom;
      if ($urandom_range(299) == 0) begin
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
